wb_bram_burst: RTL and testbench
================================

// Module: wb_bram_burst
// PURPOSE
//  Wishbone B4 slave block RAM with read and write, byte-lane selects and registered
//  incrementing bursts (CTI/BTE), giving one ack per cycle during a burst.
//  Parametrised in depth and data width. Sits on the system Wishbone bus as main
//  on-chip memory behind the interconnect.
// PARAMETERS
//  MEM_ADR_WIDTH  11  word-index width; depth = 2**MEM_ADR_WIDTH words (2048)
//  DATA_WIDTH     32  data bus width, multiple of 8; SEL_WIDTH = DATA_WIDTH/8
// PORTS (all carried by wshb_if.slave wb_s)
//  wb_s.clk     in   1           single clock, all logic on rising edge
//  wb_s.rst     in   1           asynchronous, active-high reset
//  wb_s.cyc     in   1           bus cycle valid
//  wb_s.stb     in   1           strobe / beat request
//  wb_s.we      in   1           1 = write, 0 = read
//  wb_s.sel     in   SEL_WIDTH   byte-lane enables (writes only)
//  wb_s.adr     in   32          byte address; word index = adr[MEM_ADR_WIDTH+1:2]
//  wb_s.dat_ms  in   DATA_WIDTH  write data
//  wb_s.cti     in   3           000 classic, 010 incr burst, 111 end of burst, others = classic
//  wb_s.bte     in   2           00 linear, 01 wrap4, 10 wrap8, 11 wrap16
//  wb_s.dat_sm  out  DATA_WIDTH  read data, valid when ack=1 and we=0
//  wb_s.ack     out  1           registered beat acknowledge
//  wb_s.err     out  1           tied 0
//  wb_s.rty     out  1           tied 0
// BEHAVIOUR
//  - Reset (async, any time): ack=0, dat_sm=0, state=IDLE, burst index=0. RAM contents preserved.
//  - req = cyc & stb. Address bits above the index and adr[1:0] are ignored (aliasing).
//  - Write: on every edge with req & we, write RAM[index(adr)] lanes where sel[i]=1.
//    Repeated writes of the same beat are idempotent. Reads ignore sel.
//  - FSM state IDLE, classic access (cti not 010):
//    - On an edge with req & !ack: ack<=1.
//    - For a read, dat_sm<=RAM[index(adr)] at that edge. Latency 1 cycle.
//    - Next edge: ack<=0. Back-to-back classic accesses therefore take 2 cycles per beat.
//  - FSM state IDLE, incrementing burst:
//    - On an edge with req & !ack & cti==010: ack<=1 and dat_sm<=RAM[index(adr)].
//    - Load nidx<=next(index(adr)) and go to BURST.
//  - FSM state BURST (ack=1 each edge):
//    - If !req: ack<=0, go IDLE (master wait state; the burst restarts from the master's adr).
//    - Else if cti==111, or cti not 010: ack<=0, go IDLE. This is the last beat.
//    - Else: ack<=1. On a read, dat_sm<=RAM[nidx] and nidx<=next(nidx).
//      This prefetches the next beat, giving 1 beat/cycle.
//  - next(i): bte 00 -> i+1 mod 2**MEM_ADR_WIDTH (wraps at top of memory).
//    bte 01/10/11 -> increment the low 2/3/4 bits only, upper bits held.
//  - In BURST, writes use the master's adr; nidx is only used for read prefetch.
//  - cyc dropped at any point: ack<=0 next edge, go IDLE. No pending state survives.
//  - The we value is sampled per beat. A we change mid-burst is legal: the beat is handled
//    per the current we. The read prefetch for the following beat is then discarded by
//    returning to IDLE.
// STRUCTURE
//  - Package wb_bram_pkg:
//    - cti_t enum (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111)
//    - bte_t enum (BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16)
//    - state_t {IDLE, BURST}
//    - function next_index(idx, bte)
//  - Sub-module bram_sp_be: single-port RAM, DATA_WIDTH x 2**MEM_ADR_WIDTH.
//    Per-byte write enable, registered read output. The top level holds the FSM, ack and
//    address generation.
// TESTING
//  1 Reset: rst pulse mid-burst -> ack=0 and dat_sm=0 immediately (async); RAM word 5
//    written before reset still reads back 32'hCAFE0005.
//  2 Classic: write 32'h12345678 @adr 0x10 sel=4'hF, then read 0x10 -> ack 1 cycle after
//    stb, dat_sm=32'h12345678. Read 0x2010 (alias, depth 2048) -> same data.
//  3 Byte lanes: write 32'hAABBCCDD sel=4'b0101 over 32'h0 @0x20 -> read 0x20 = 32'h00BB00DD.
//  4 Linear burst read: words 0..7 preloaded i*3; cti=010 @0x00 for 7 beats then cti=111
//    -> 8 consecutive acks, data 0,3,...,21, ack=0 the cycle after.
//  5 Wrap4 burst read @adr 0x38 (idx 14), bte=01 -> data order idx 14,15,12,13.
//    Linear burst @ idx 2047 -> next beat returns idx 0.
//  6 Burst write 4 beats @0x100 with stb low for 1 cycle after beat 2 -> ack drops during
//    the wait, all 4 words written correctly, no duplicate/skipped beat. cyc drop mid-read
//    burst -> ack=0 next cycle.

Source files
------------

// File: rtl/wb_bram_pkg.sv
// Shared types and burst address helper for the Wishbone burst block RAM.
package wb_bram_pkg;

  // Wishbone cycle type identifier; unlisted codes behave as classic cycles.
  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_t;

  // Burst type extension: linear or wrap on a 4/8/16-word boundary.
  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_t;

  // Slave FSM: IDLE handles classic beats and burst starts, BURST streams beats.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width used by next_index; callers truncate the result to their index width,
  // which gives the linear wrap at the top of memory for free.
  localparam int unsigned IDX_CALC_WIDTH = 32;

  // Next word index of a burst. Wrapping bursts only increment the low bits
  // and hold the upper bits, so the sequence stays inside its aligned block.
  function automatic logic [IDX_CALC_WIDTH-1:0] next_index(
    input logic [IDX_CALC_WIDTH-1:0] idx,
    input bte_t                      bte
  );
    logic [IDX_CALC_WIDTH-1:0] mask;
    logic [IDX_CALC_WIDTH-1:0] inc;
    inc  = idx + 32'd1;
    mask = '1;
    case (bte)
      BTE_LINEAR: mask = '1;
      BTE_WRAP4:  mask = 32'h0000_0003;
      BTE_WRAP8:  mask = 32'h0000_0007;
      BTE_WRAP16: mask = 32'h0000_000F;
    endcase
    return (idx & ~mask) | (inc & mask);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with master and slave views; clock and reset ride along.
interface wshb_if #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [SEL_WIDTH-1:0]  sel;
  logic [31:0]           adr;
  logic [DATA_WIDTH-1:0] dat_ms;
  logic [2:0]            cti;
  logic [1:0]            bte;
  logic [DATA_WIDTH-1:0] dat_sm;
  logic                  ack;
  logic                  err;
  logic                  rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output cyc, stb, we, sel, adr, dat_ms, cti, bte
  );

  modport slave (
    input  clk, rst, cyc, stb, we, sel, adr, dat_ms, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/bram_sp_be.sv
// Single-port block RAM with per-byte write enables and a registered read port.
// The array itself has no reset so it maps onto block RAM and keeps its contents
// across a bus reset; only the read register is cleared.
module bram_sp_be #(
  parameter int unsigned ADR_WIDTH  = 11,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic                    i_re,
  input  logic [ADR_WIDTH-1:0]    i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Byte-lane write into the array.
  always_ff @(posedge i_clk) begin
    for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
      if (i_we && i_be[b]) begin
        r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; holds its value between read strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_bram_burst.sv
// Wishbone B4 slave block RAM with byte lanes and registered incrementing bursts.
// Classic beats take two cycles (ack, then ack low); incrementing bursts prefetch
// the next word every cycle so reads stream at one beat per clock.
module wb_bram_burst
  import wb_bram_pkg::*;
#(
  parameter int unsigned MEM_ADR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH    = 32
) (
  wshb_if.slave wb_s
);

  localparam int unsigned AW = MEM_ADR_WIDTH;

  logic                  w_clk;
  logic                  w_rst;
  logic                  w_req;
  logic                  w_incr;
  logic                  w_wr;
  logic                  w_re;
  bte_t                  w_bte;
  logic [AW-1:0]         w_idx;
  logic [AW-1:0]         w_raddr;
  logic [AW-1:0]         w_ram_addr;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ack;
  logic                  w_ack_nxt;
  logic                  r_we;
  logic [AW-1:0]         r_nidx;
  logic [AW-1:0]         w_nidx_nxt;

  assign w_clk  = wb_s.clk;
  assign w_rst  = wb_s.rst;
  assign w_req  = wb_s.cyc & wb_s.stb;
  assign w_incr = (wb_s.cti == CTI_INCR);
  assign w_bte  = bte_t'(wb_s.bte);
  // Address bits outside the word index alias onto the same memory.
  assign w_idx  = wb_s.adr[AW+1:2];
  assign w_unused = ^{wb_s.adr[31:AW+2], wb_s.adr[1:0]};

  // Writes always target the master's address, on every requested write edge.
  assign w_wr = w_req & wb_s.we;

  // Single RAM port: reads are only issued on read beats, so the write address
  // wins whenever a write is in flight.
  assign w_ram_addr = w_wr ? w_idx : w_raddr;

  // Next-state, ack and read-prefetch decode.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_nidx_nxt  = r_nidx;
    w_re        = 1'b0;
    w_raddr     = w_idx;
    unique case (r_state)
      IDLE: begin
        // ack low on the cycle after a classic ack gives the 2-cycle classic beat.
        if (w_req && !r_ack) begin
          w_ack_nxt = 1'b1;
          w_re      = !wb_s.we;
          if (w_incr) begin
            w_state_nxt = BURST;
            w_nidx_nxt  = AW'(next_index(32'(w_idx), w_bte));
          end
        end
      end
      BURST: begin
        // A wait state, end of burst, classic cycle, or a change of direction
        // ends streaming; any outstanding prefetch is simply dropped.
        if (w_req && w_incr && (wb_s.we == r_we)) begin
          w_ack_nxt = 1'b1;
          if (!wb_s.we) begin
            w_re       = 1'b1;
            w_raddr    = r_nidx;
            w_nidx_nxt = AW'(next_index(32'(r_nidx), w_bte));
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, ack, prefetch index and last-beat direction registers.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_nidx  <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_nidx  <= w_nidx_nxt;
      if (w_req) begin
        r_we <= wb_s.we;
      end
    end
  end

  bram_sp_be #(
    .ADR_WIDTH  (AW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk   (w_clk),
    .i_rst   (w_rst),
    .i_we    (w_wr),
    .i_be    (wb_s.sel),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (wb_s.dat_ms),
    .o_rdata (w_rdata)
  );

  assign wb_s.dat_sm = w_rdata;
  assign wb_s.ack    = r_ack;
  assign wb_s.err    = 1'b0;
  assign wb_s.rty    = 1'b0;

endmodule

// File: tb/tb_wb_bram_burst.sv
// Directed bench for wb_bram_burst: classic, byte lanes, linear/wrap bursts,
// burst writes with a wait state, cyc abort and asynchronous reset.
module tb_wb_bram_burst;
  import wb_bram_pkg::*;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  logic [31:0] b_adr [8];
  logic [31:0] b_exp [8];

  wshb_if #(.DATA_WIDTH(32)) u_if (
    .clk (clk),
    .rst (rst)
  );

  wb_bram_burst #(
    .MEM_ADR_WIDTH (11),
    .DATA_WIDTH    (32)
  ) u_dut (
    .wb_s (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    u_if.cyc    = 1'b0;
    u_if.stb    = 1'b0;
    u_if.we     = 1'b0;
    u_if.sel    = 4'h0;
    u_if.adr    = 32'h0;
    u_if.dat_ms = 32'h0;
    u_if.cti    = CTI_CLASSIC;
    u_if.bte    = BTE_LINEAR;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] cti, input logic [1:0] bte);
    u_if.cyc    = 1'b1;
    u_if.stb    = 1'b1;
    u_if.we     = we;
    u_if.adr    = a;
    u_if.dat_ms = d;
    u_if.sel    = s;
    u_if.cti    = cti;
    u_if.bte    = bte;
  endtask

  task automatic wr_classic(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    drive(1'b1, a, d, s, CTI_CLASSIC, BTE_LINEAR);
    tick();
    check_eq("wr_ack", 32'(u_if.ack), 32'd1);
    tick();
    check_eq("wr_ack_drop", 32'(u_if.ack), 32'd0);
    bus_idle();
  endtask

  task automatic rd_classic(input string tag, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b0, a, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    tick();
    check_eq({tag, "_ack"}, 32'(u_if.ack), 32'd1);
    check_eq({tag, "_dat"}, u_if.dat_sm, exp);
    tick();
    check_eq({tag, "_ack_drop"}, 32'(u_if.ack), 32'd0);
    bus_idle();
  endtask

  // Read burst over b_adr[0..n-1]; last beat flagged end-of-burst.
  task automatic rd_burst(input string tag, input int n, input logic [1:0] bte);
    drive(1'b0, b_adr[0], 32'h0, 4'h0, (n == 1) ? CTI_EOB : CTI_INCR, bte);
    tick();
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s_ack%0d", tag, k), 32'(u_if.ack), 32'd1);
      check_eq($sformatf("%s_dat%0d", tag, k), u_if.dat_sm, b_exp[k]);
      tick();
      if (k < n - 1) begin
        drive(1'b0, b_adr[k+1], 32'h0, 4'h0, (k + 1 == n - 1) ? CTI_EOB : CTI_INCR, bte);
      end
    end
    check_eq({tag, "_end"}, 32'(u_if.ack), 32'd0);
    bus_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack", 32'(u_if.ack), 32'd0);
    check_eq("rst_dat", u_if.dat_sm, 32'h0);
    check_eq("rst_err", 32'(u_if.err), 32'd0);
    check_eq("rst_rty", 32'(u_if.rty), 32'd0);
    rst = 1'b0;
    tick();

    // Classic write/read and address aliasing.
    wr_classic(32'h10, 32'h1234_5678, 4'hF);
    rd_classic("cls", 32'h10, 32'h1234_5678);
    rd_classic("alias", 32'h2010, 32'h1234_5678);

    // Byte lanes 0 and 2 only.
    wr_classic(32'h20, 32'h0, 4'hF);
    wr_classic(32'h20, 32'hAABB_CCDD, 4'b0101);
    rd_classic("lanes", 32'h20, 32'h00BB_00DD);

    // Linear 8-beat burst over words 0..7 holding i*3.
    for (int i = 0; i < 8; i++) wr_classic(32'(i * 4), 32'(i * 3), 4'hF);
    for (int i = 0; i < 8; i++) begin
      b_adr[i] = 32'(i * 4);
      b_exp[i] = 32'(i * 3);
    end
    rd_burst("lin", 8, BTE_LINEAR);

    // Wrap4 burst starting at word 14.
    for (int i = 12; i < 16; i++) wr_classic(32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF);
    b_adr[0] = 32'h38; b_exp[0] = 32'hC0DE_000E;
    b_adr[1] = 32'h3C; b_exp[1] = 32'hC0DE_000F;
    b_adr[2] = 32'h30; b_exp[2] = 32'hC0DE_000C;
    b_adr[3] = 32'h34; b_exp[3] = 32'hC0DE_000D;
    rd_burst("wrap4", 4, BTE_WRAP4);

    // Linear burst across the top of memory wraps to word 0.
    wr_classic(32'h1FFC, 32'h7FF0_7FF0, 4'hF);
    b_adr[0] = 32'h1FFC; b_exp[0] = 32'h7FF0_7FF0;
    b_adr[1] = 32'h0000; b_exp[1] = 32'h0;
    rd_burst("top", 2, BTE_LINEAR);

    // Asynchronous reset in the middle of a read burst.
    wr_classic(32'h14, 32'hCAFE_0005, 4'hF);
    drive(1'b0, 32'h14, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
    tick();
    tick();
    drive(1'b0, 32'h18, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
    check_eq("mid_burst_ack", 32'(u_if.ack), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_ack", 32'(u_if.ack), 32'd0);
    check_eq("async_rst_dat", u_if.dat_sm, 32'h0);
    bus_idle();
    tick();
    rst = 1'b0;
    tick();
    rd_classic("keep", 32'h14, 32'hCAFE_0005);

    // Burst write with a one-cycle stb wait after the third beat.
    drive(1'b1, 32'h100, 32'hB000_0000, 4'hF, CTI_INCR, BTE_LINEAR);
    tick();
    check_eq("bw_ack0", 32'(u_if.ack), 32'd1);
    tick();
    drive(1'b1, 32'h104, 32'hB000_0001, 4'hF, CTI_INCR, BTE_LINEAR);
    check_eq("bw_ack1", 32'(u_if.ack), 32'd1);
    tick();
    drive(1'b1, 32'h108, 32'hB000_0002, 4'hF, CTI_INCR, BTE_LINEAR);
    check_eq("bw_ack2", 32'(u_if.ack), 32'd1);
    tick();
    u_if.stb = 1'b0;
    tick();
    check_eq("bw_wait_ack", 32'(u_if.ack), 32'd0);
    drive(1'b1, 32'h10C, 32'hB000_0003, 4'hF, CTI_EOB, BTE_LINEAR);
    tick();
    check_eq("bw_ack3", 32'(u_if.ack), 32'd1);
    tick();
    check_eq("bw_end", 32'(u_if.ack), 32'd0);
    bus_idle();
    rd_classic("bw_w0", 32'h100, 32'hB000_0000);
    rd_classic("bw_w1", 32'h104, 32'hB000_0001);
    rd_classic("bw_w2", 32'h108, 32'hB000_0002);
    rd_classic("bw_w3", 32'h10C, 32'hB000_0003);

    // cyc dropped mid read burst.
    drive(1'b0, 32'h0, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
    tick();
    check_eq("abort_dat0", u_if.dat_sm, 32'h0);
    tick();
    drive(1'b0, 32'h4, 32'h0, 4'h0, CTI_INCR, BTE_LINEAR);
    check_eq("abort_ack1", 32'(u_if.ack), 32'd1);
    check_eq("abort_dat1", u_if.dat_sm, 32'd3);
    u_if.cyc = 1'b0;
    tick();
    check_eq("abort_ack_drop", 32'(u_if.ack), 32'd0);
    bus_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
